// File: rtl/lea_message_loader.sv
// Packs four WORD_W plaintext words into one LEA message block and strobes it into
// the message register when the core is ready. Optional macro: LEA_LOADER_BYTESWAP_EN.
module lea_message_loader #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [WORD_W-1:0]     in_data,
    output logic                  in_ready,
    input  logic                  core_ready,
    output logic [4*WORD_W-1:0]   msg_data,
    output logic                  msg_ce,
    output logic [CNT_W-1:0]      blk_cnt,
    output logic [1:0]            dbg_state
);

    // Handshake: a word transfers at a rising edge where in_valid and in_ready are
    // both high and flush is low; the source holds in_valid/in_data until then.
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [4*WORD_W-1:0]   msg_q, msg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WORD_W-1:0]     store_word;

`ifdef LEA_LOADER_BYTESWAP_EN
    // Big-endian sources: reverse byte order so LEA sees its little-endian words.
    always_comb begin
        store_word = '0;
        for (int b = 0; b < WORD_W / 8; b++) begin
            store_word[8*b +: 8] = in_data[WORD_W-8-8*b +: 8];
        end
    end
`else
    assign store_word = in_data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            msg_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            msg_q   <= msg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        msg_d    = msg_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        msg_ce   = 1'b0;

        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    for (int i = 0; i < 4; i++) begin
                        if (idx_q == i[1:0]) begin
                            msg_d[WORD_W*i +: WORD_W] = store_word;
                        end
                    end
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (core_ready) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The strobe and the count stand even if flush arrives this cycle.
                msg_ce  = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = FILL;
                idx_d   = '0;
            end
            default: begin
                state_d = FILL;
                idx_d   = '0;
            end
        endcase

        if (flush) begin
            state_d = FILL;
            idx_d   = '0;
        end
    end

    assign msg_data  = msg_q;
    assign blk_cnt   = cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lea_message_loader.sv
// Self-checking bench for lea_message_loader against a word-queue reference model.
module tb_lea_message_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [31:0]  in_data = '0;
    logic         core_ready = 1'b0;
    logic         in_ready, msg_ce;
    logic [127:0] msg_data;
    logic [15:0]  blk_cnt;
    logic [1:0]   dbg_state;
    logic         in_ready_w, msg_ce_w;
    logic [127:0] msg_data_w;
    logic [2:0]   blk_cnt_w;
    logic [1:0]   dbg_state_w;

    int n_checks = 0;
    int n_fails  = 0;
    int exp_cnt  = 0;
    logic [127:0] exp_q[$];
    logic [31:0]  word_q[$];

    lea_message_loader #(.WORD_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .core_ready(core_ready), .msg_data(msg_data),
        .msg_ce(msg_ce), .blk_cnt(blk_cnt), .dbg_state(dbg_state)
    );

    // Narrow counter copy on the same stimulus: exposes the wrap after 8 blocks.
    lea_message_loader #(.WORD_W(32), .CNT_W(3)) dut_w (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_w), .core_ready(core_ready), .msg_data(msg_data_w),
        .msg_ce(msg_ce_w), .blk_cnt(blk_cnt_w), .dbg_state(dbg_state_w)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_store(input logic [31:0] w);
`ifdef LEA_LOADER_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic void model_accept(input logic [31:0] w);
        logic [127:0] blk;
        word_q.push_back(w);
        if (word_q.size() == 4) begin
            blk = '0;
            for (int i = 0; i < 4; i++) blk[32*i +: 32] = model_store(word_q[i]);
            exp_q.push_back(blk);
            word_q.delete();
        end
    endfunction

    function automatic void model_reset();
        word_q.delete();
        exp_q.delete();
        exp_cnt = 0;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the edge that took the word.
    task automatic send_word(input logic [31:0] w, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_checks++; n_fails++;
            $display("FAIL send_word timeout: in_ready=%0b required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            model_accept(w);
        end
    endtask

    task automatic wait_ce(input int limit, output int cycles, output bit seen);
        cycles = 0;
        while (!msg_ce && cycles < limit) begin
            @(posedge clk); #1;
            cycles++;
        end
        seen = msg_ce;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (msg_data !== 128'h0) begin n_fails++; $display("FAIL reset_msg_data: got %h required 0", msg_data); end
        n_checks++;
        if (msg_ce !== 1'b0) begin n_fails++; $display("FAIL reset_msg_ce: got %b required 0", msg_ce); end
        n_checks++;
        if (blk_cnt !== 16'h0) begin n_fails++; $display("FAIL reset_blk_cnt: got %0d required 0", blk_cnt); end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic issue_and_check(input string name, input int exp_lat);
        int cyc; bit seen; logic [127:0] exp_blk;
        wait_ce(8, cyc, seen);
        n_checks++;
        if (!seen || cyc != exp_lat) begin
            n_fails++;
            $display("FAIL %s_latency: seen=%0b cycles=%0d required seen=1 cycles=%0d", name, seen, cyc, exp_lat);
        end
        exp_blk = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        n_checks++;
        if (msg_data !== exp_blk) begin n_fails++; $display("FAIL %s_block: got %h required %h", name, msg_data, exp_blk); end
        if (seen) exp_cnt++;
        @(posedge clk); #1;
        n_checks++;
        if (msg_ce !== 1'b0 || blk_cnt !== 16'(exp_cnt)) begin
            n_fails++;
            $display("FAIL %s_after: msg_ce=%b blk_cnt=%0d required 0 and %0d", name, msg_ce, blk_cnt, 16'(exp_cnt));
        end
    endtask

    task automatic test_basic_block();
        logic [31:0] words [4];
        words = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        core_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_word(words[i], 0);
        n_checks++;
        if (msg_ce !== 1'b0 || in_ready !== 1'b0) begin
            n_fails++; $display("FAIL basic_hold: msg_ce=%b in_ready=%b required 0 0", msg_ce, in_ready);
        end
`ifndef LEA_LOADER_BYTESWAP_EN
        n_checks++;
        if (msg_data !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin
            n_fails++; $display("FAIL basic_literal: got %h required 0f0e0d0c0b0a090807060504030201 00", msg_data);
        end
`endif
        issue_and_check("basic", 1);
    endtask

    task automatic test_backpressure();
        core_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word($urandom, 0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (in_ready !== 1'b0 || msg_ce !== 1'b0 || msg_data !== exp_q[0]) begin
                n_fails++;
                $display("FAIL hold_stall: in_ready=%b msg_ce=%b data=%h required 0 0 %h", in_ready, msg_ce, msg_data, exp_q[0]);
            end
        end
        core_ready = 1'b1;
        issue_and_check("hold_release", 1);
    endtask

    task automatic test_flush();
        logic [31:0] w0, w1;
        int cyc; bit seen; logic [127:0] exp_blk;
        core_ready = 1'b1;
        w0 = $urandom; w1 = $urandom;
        send_word(w0, 0);
        send_word(w1, 0);
        in_valid = 1'b1; in_data = 32'hDEADBEEF; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        word_q.delete();
        n_checks++;
        if (in_ready !== 1'b1 || msg_data[63:0] !== {model_store(w1), model_store(w0)}) begin
            n_fails++;
            $display("FAIL flush_fill: in_ready=%b low=%h required 1 %h", in_ready, msg_data[63:0], {model_store(w1), model_store(w0)});
        end
        for (int i = 0; i < 4; i++) send_word($urandom, 0);
        issue_and_check("flush_refill", 1);

        core_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word($urandom, 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        core_ready = 1'b1;
        wait_ce(3, cyc, seen);
        n_checks++;
        if (seen || in_ready !== 1'b1 || blk_cnt !== 16'(exp_cnt)) begin
            n_fails++;
            $display("FAIL flush_hold: ce_seen=%0b in_ready=%b blk_cnt=%0d required 0 1 %0d", seen, in_ready, blk_cnt, 16'(exp_cnt));
        end

        for (int i = 0; i < 4; i++) send_word($urandom, 0);
        wait_ce(8, cyc, seen);
        flush = 1'b1;
        exp_blk = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        n_checks++;
        if (!seen || msg_data !== exp_blk) begin
            n_fails++; $display("FAIL flush_issue_block: seen=%0b got %h required %h", seen, msg_data, exp_blk);
        end
        if (seen) exp_cnt++;
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks++;
        if (blk_cnt !== 16'(exp_cnt) || in_ready !== 1'b1 || msg_ce !== 1'b0) begin
            n_fails++;
            $display("FAIL flush_issue_after: blk_cnt=%0d in_ready=%b msg_ce=%b required %0d 1 0", blk_cnt, in_ready, msg_ce, 16'(exp_cnt));
        end
    endtask

    task automatic test_reset_mid();
        core_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_word($urandom, 0);
        rst = 1'b0;
        #1;
        n_checks++;
        if (msg_data !== 128'h0 || msg_ce !== 1'b0 || blk_cnt !== 16'h0) begin
            n_fails++;
            $display("FAIL reset_mid: data=%h ce=%b cnt=%0d required 0 0 0", msg_data, msg_ce, blk_cnt);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send_word($urandom, 0);
        issue_and_check("reset_recover", 1);
    endtask

    task automatic test_random_stream();
        core_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 4; i++) send_word($urandom, $urandom_range(0, 3));
            issue_and_check("random", 1);
            n_checks++;
            if (blk_cnt_w !== 3'(exp_cnt % 8)) begin
                n_fails++; $display("FAIL wrap_cnt: got %0d required %0d", blk_cnt_w, exp_cnt % 8);
            end
        end
    endtask

    task automatic test_slot0();
        logic [31:0] exp_lo;
`ifdef LEA_LOADER_BYTESWAP_EN
        exp_lo = 32'h33221100;
`else
        exp_lo = 32'h00112233;
`endif
        core_ready = 1'b0;
        send_word(32'h00112233, 0);
        for (int i = 0; i < 3; i++) send_word($urandom, 0);
        n_checks++;
        if (msg_data[31:0] !== exp_lo) begin
            n_fails++; $display("FAIL slot0_store: got %h required %h", msg_data[31:0], exp_lo);
        end
        core_ready = 1'b1;
        issue_and_check("slot0", 1);
    endtask

    initial begin
        test_reset();
        test_basic_block();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random_stream();
        test_slot0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
